// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair with single-cycle multiply/accumulate
// and a WIDTH+1 cycle restoring divider.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, op, a, b     operation request, opcode, operands
//   flush               abort an in-flight divide
//   busy, done, hilo_o  divide busy, divide done pulse, {HI, LO}
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo_o
);

  localparam logic [3:0] OP_MTHI  = 4'd1;
  localparam logic [3:0] OP_MTLO  = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_DIV   = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;

  logic accept;
  logic is_mthi;
  logic is_mtlo;
  logic is_mul;
  logic is_madd;
  logic is_msub;
  logic is_div;
  logic sgn;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign hilo_o = {hi, lo};

  assign accept  = (state == IDLE) && start && !flush;
  assign is_mthi = (op == OP_MTHI);
  assign is_mtlo = (op == OP_MTLO);
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_madd = (op == OP_MADD) || (op == OP_MADDU);
  assign is_msub = (op == OP_MSUB) || (op == OP_MSUBU);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn     = (op == OP_MULT) || (op == OP_MADD)
                || (op == OP_MSUB) || (op == OP_DIV);

  // Full-width operands so the low 2*WIDTH product bits are exact
  always_comb begin
    prod_s = {{WIDTH{a[WIDTH-1]}}, a}
           * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    prod   = sgn ? prod_s : prod_u;
    mul_res = prod;
    unique case (1'b1)
      is_madd: mul_res = {hi, lo} + prod;
      is_msub: mul_res = {hi, lo} - prod;
      default: mul_res = prod;
    endcase
  end

  always_comb begin
    a_neg = sgn && a[WIDTH-1];
    b_neg = sgn && b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One restoring step: shift in next dividend bit, trial subtract
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    ge     = rem_sh >= {1'b0, dvsr};
    rem_nx = ge ? (rem_sh[WIDTH-1:0] - dvsr)
                : rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ge};
  end

  // Negating 2^(WIDTH-1) wraps to itself: covers MIN / -1
  always_comb begin
    quo_fix = neg_q ? -quo : quo;
    rem_fix = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dvsr   <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_mthi: hi <= a;
              is_mtlo: lo <= a;
              is_mul, is_madd, is_msub: begin
                {hi, lo} <= mul_res;
              end
              is_div: begin
                state  <= DIV;
                busy   <= 1'b1;
                quo    <= a_mag;
                rem    <= '0;
                dvsr   <= b_mag;
                cnt    <= '0;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                b_zero <= (b == '0);
              end
              default: ;
            endcase
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            quo <= quo_nx;
            rem <= rem_nx;
            if (cnt == LAST) begin
              state <= FIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (!b_zero) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: randomized and directed checks of hilo_unit (WIDTH=32)
// against an arithmetic reference model of HI/LO.
module tb_hilo_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          flush;
  logic          busy;
  logic          done;
  logic [2*W-1:0] hilo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] m;

  hilo_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hilo_o (hilo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [3:0] o,
    input logic [31:0] x, input logic [31:0] y,
    input logic [63:0] cur);
    longint sp;
    logic [63:0] up;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = {32'b0, x} * {32'b0, y};
    case (o)
      4'd1: return {x, cur[31:0]};
      4'd2: return {cur[63:32], x};
      4'd3: return sp;
      4'd4: return up;
      4'd5: return cur + sp;
      4'd6: return cur + up;
      4'd7: return cur - sp;
      4'd8: return cur - up;
      default: return cur;
    endcase
  endfunction

  function automatic logic [63:0] div_model(input logic [3:0] o,
    input logic [31:0] x, input logic [31:0] y,
    input logic [63:0] cur);
    longint sx, sy, q, r;
    logic [31:0] uq, ur;
    if (y == 0) return cur;
    if (o == 4'd9) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    uq = x / y;
    ur = x % y;
    return {ur, uq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    op = 4'd0;
  endtask

  // Runs a divide; a stray MTHI is attempted during busy and must vanish.
  // With chain set, an MTLO is issued in the done cycle.
  task automatic run_div(input logic [3:0] o, input logic [31:0] x,
    input logic [31:0] y, input string tag, input bit chain);
    int n;
    bit bad;
    logic [63:0] e;
    e = div_model(o, x, y, m);
    do_op(o, x, y);
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 100) begin
      if (done !== 1'b0) bad = 1;
      if (n == 4) begin
        start = 1'b1;
        op = 4'd1;
        a = $urandom;
      end else begin
        start = 1'b0;
        op = 4'd0;
      end
      n++;
      tick();
    end
    start = 1'b0;
    op = 4'd0;
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " done_in_busy"}, 64'(bad), 64'd0);
    check({tag, " hilo"}, hilo, e);
    m = e;
    if (chain) begin
      do_op(4'd2, 32'hC0FFEE00, 32'd0);
      m = {m[63:32], 32'hC0FFEE00};
    end else begin
      tick();
    end
    check({tag, " done_drop"}, 64'(done), 64'd0);
    check({tag, " hilo_after"}, hilo, m);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int nd;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = 4'd0;
    a = '0;
    b = '0;
    m = '0;
    tick();
    tick();
    check("rst hilo", hilo, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    rst_n = 1'b1;

    do_op(4'd3, 32'hFFFFFFFF, 32'd2);
    check("mult", hilo, 64'hFFFFFFFF_FFFFFFFE);
    check("mult busy", 64'(busy), 64'd0);
    do_op(4'd6, 32'd1, 32'd2);
    check("maddu wrap", hilo, 64'd0);
    check("maddu done", 64'(done), 64'd0);
    m = 64'd0;

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      if (ro == 4'd9 || ro == 4'd10) ro = 4'd0;
      ra = $urandom;
      rb = $urandom;
      do_op(ro, ra, rb);
      m = mul_model(ro, ra, rb, m);
      check($sformatf("rnd op%0d hilo", ro), hilo, m);
      check($sformatf("rnd op%0d busy_done", ro),
            {62'd0, busy, done}, 64'd0);
    end

    run_div(4'd9, 32'hFFFFFFF9, 32'd2, "div -7/2", 1'b0);
    check("div -7/2 lit", hilo, 64'hFFFFFFFF_FFFFFFFD);

    do_op(4'd1, 32'h11, 32'd0);
    do_op(4'd2, 32'h22, 32'd0);
    m = {32'h11, 32'h22};
    run_div(4'd10, 32'd100, 32'd0, "divu /0", 1'b0);
    check("divu /0 lit", hilo, {32'h11, 32'h22});

    run_div(4'd9, 32'h80000000, 32'hFFFFFFFF, "div min/-1", 1'b0);
    check("div min/-1 lit", hilo, {32'h0, 32'h80000000});

    run_div(4'd9, 32'd1000, 32'hFFFFFFF9, "div chain", 1'b1);

    for (int i = 0; i < 8; i++) begin
      ro = 4'($urandom_range(9, 10));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                       : $urandom;
      run_div(ro, ra, rb, $sformatf("rnd div%0d", i), 1'b0);
    end

    do_op(4'd1, 32'hAAAA5555, 32'd0);
    do_op(4'd2, 32'h12345678, 32'd0);
    m = {32'hAAAA5555, 32'h12345678};
    do_op(4'd10, $urandom, 32'd7);
    check("flush busy1", 64'(busy), 64'd1);
    for (int k = 1; k < 10; k++) begin
      if (k == 3) begin
        start = 1'b1;
        op = 4'd2;
        a = 32'd5;
      end else begin
        start = 1'b0;
        op = 4'd0;
      end
      tick();
    end
    start = 1'b0;
    op = 4'd0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hilo", hilo, m);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0) nd++;
      tick();
    end
    check("flush no done", 64'(nd), 64'd0);
    check("flush hilo later", hilo, m);
    do_op(4'd2, 32'd5, 32'd0);
    m = {m[63:32], 32'd5};
    check("mtlo after flush", hilo, m);

    flush = 1'b1;
    do_op(4'd1, 32'hDEADBEEF, 32'd0);
    flush = 1'b0;
    check("idle flush blocks", hilo, m);

    do_op(4'd1, 32'h1234, 32'd0);
    m = {32'h1234, m[31:0]};
    do_op(4'd9, $urandom, 32'd3);
    for (int k = 1; k < 20; k++) tick();
    check("pre-rst busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #2;
    check("rst sync hilo", hilo, m);
    check("rst sync busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("midrst hilo", hilo, 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    m = 64'd0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0) nd++;
      tick();
    end
    check("midrst no done", 64'(nd), 64'd0);
    check("midrst hilo later", hilo, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
